// File: rtl/logic_reduce_pkg.sv
// Shared mode encodings and per-mode identity element for logic_reduce_n.
package logic_reduce_pkg;

   localparam logic [2:0] MODE_OR   = 3'b000;
   localparam logic [2:0] MODE_AND  = 3'b001;
   localparam logic [2:0] MODE_XOR  = 3'b010;
   localparam logic [2:0] MODE_NOR  = 3'b011;
   localparam logic [2:0] MODE_NAND = 3'b100;
   localparam logic [2:0] MODE_XNOR = 3'b101;

   // Value a masked channel contributes so it cannot influence the reduction.
   function automatic logic mode_identity(input logic [2:0] mode);
      return (mode == MODE_AND) || (mode == MODE_NAND);
   endfunction

endpackage

// File: rtl/input_debounce.sv
// One input channel: 2-flop synchroniser followed by a stability filter.
module input_debounce #(
   parameter int unsigned FILT_CYC = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic x,
   output logic f
);

   localparam int unsigned CW = $clog2(FILT_CYC) + 1;

   logic          sync1_q, s_q;
   logic          f_q, f_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      f_d   = f_q;
      cnt_d = '0;
      if (s_q != f_q) begin
         if (cnt_q == CW'(FILT_CYC - 1)) begin
            f_d = s_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         f_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= x;
         s_q     <= sync1_q;
         f_q     <= f_d;
         cnt_q   <= cnt_d;
      end
   end

   assign f = f_q;

endmodule

// File: rtl/logic_reduce_n.sv
// N-input debounced logic reduction with run-time mode, rise pulse, rise counter and sticky flag.
module logic_reduce_n
   import logic_reduce_pkg::*;
#(
   parameter int unsigned N        = 3,
   parameter int unsigned FILT_CYC = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N-1:0]     x,
   input  logic [2:0]       mode,
   input  logic [N-1:0]     mask,
   input  logic             sticky_en,
   input  logic             clr,
   output logic             z0,
   output logic             z_rise,
   output logic [CNT_W-1:0] rise_cnt,
   output logic             z_sticky
);

   logic [N-1:0]     f, m;
   logic             ident, r, rise;
   logic             z0_q, z_rise_q, z_sticky_q, z_sticky_d;
   logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;

   for (genvar i = 0; i < N; i++) begin : g_ch
      input_debounce #(
         .FILT_CYC (FILT_CYC)
      ) u_deb (
         .clk  (clk),
         .rstn (rstn),
         .x    (x[i]),
         .f    (f[i])
      );
   end

   always_comb begin
      ident = mode_identity(mode);
      m     = (f & mask) | (~mask & {N{ident}});
      case (mode)
         MODE_AND:  r = &m;
         MODE_XOR:  r = ^m;
         MODE_NOR:  r = ~|m;
         MODE_NAND: r = ~&m;
         MODE_XNOR: r = ~^m;
         default:   r = |m;   // OR and the reserved 11x codes
      endcase
   end

   always_comb begin
      rise       = r & ~z0_q;
      rise_cnt_d = rise_cnt_q;
      z_sticky_d = z_sticky_q | (sticky_en & r);
      if (clr) begin
         rise_cnt_d = '0;
         z_sticky_d = 1'b0;
      end else if (rise && (rise_cnt_q != {CNT_W{1'b1}})) begin
         rise_cnt_d = rise_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         z0_q       <= 1'b0;
         z_rise_q   <= 1'b0;
         rise_cnt_q <= '0;
         z_sticky_q <= 1'b0;
      end else begin
         z0_q       <= r;
         z_rise_q   <= rise;
         rise_cnt_q <= rise_cnt_d;
         z_sticky_q <= z_sticky_d;
      end
   end

   assign z0       = z0_q;
   assign z_rise   = z_rise_q;
   assign rise_cnt = rise_cnt_q;
   assign z_sticky = z_sticky_q;

endmodule

// File: doc/logic_reduce_n.md
Name: logic_reduce_n

Overview:
- Parametrised N-input logic reduction gate; successor of the fixed 3-input OR gate.
- Each input is synchronised and debounced, then masked and reduced. The reduction mode is selectable at run time.
- The output is registered, with rising-edge pulse, saturating event counter and sticky flag.
- Sits between board inputs (buttons, switches) and the LED/logic blocks in the logic_gates examples.

Parameters:
- N, 3, number of input channels (>=1)
- FILT_CYC, 4, consecutive stable cycles required before a filtered input changes (>=1)
- CNT_W, 8, width of rise_cnt

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- x  in  N  raw inputs, asynchronous to clk
- mode  in  3  reduction select: 000 OR, 001 AND, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 11x reserved (behaves as OR)
- mask  in  N  1 = channel participates; 0 = channel forced to the identity element of the mode
- sticky_en  in  1  enables setting of z_sticky
- clr  in  1  synchronous clear of z_sticky and rise_cnt
- z0  out  1  registered reduced output
- z_rise  out  1  one-cycle pulse on each 0->1 transition of z0
- rise_cnt  out  CNT_W  count of z0 rises, saturating
- z_sticky  out  1  latched high after z0 is high with sticky_en=1

Behaviour:
- Reset (rstn low, asynchronous): all flops go to 0. This covers the sync stages, filter counters, filtered values f, z0, z_rise, rise_cnt and z_sticky.
- Sync: per channel, 2-flop synchroniser, giving s[i].
- Filter, per channel:
  - While s[i]==f[i], the counter is held at 0.
  - While s[i]!=f[i], the counter increments each cycle.
  - When the counter==FILT_CYC-1 and s[i]!=f[i], then f[i]<=s[i] and the counter<=0.
  - Any return of s[i] to f[i] before that point zeroes the counter, so no change occurs.
- Masking: m[i] = mask[i] ? f[i] : identity.
  - Identity is 1 for AND/NAND and 0 for OR/XOR/NOR/XNOR/reserved.
- Reduction: r = OR/AND/XOR of m, inverted for NOR/NAND/XNOR.
  - All channels masked gives: OR 0, AND 1, XOR 0, NOR 1, NAND 0, XNOR 1.
- Output register: z0<=r every cycle. mode and mask changes appear on z0 after 1 clk edge.
- After reset release, z0 takes reduce(f=0) at the first edge; for example NOR gives 1 at edge 1.
- Latency: x changes before edge 1 and is held stable:
  - s updates at edge 2;
  - f updates at edge 2+FILT_CYC;
  - z0 updates at edge 3+FILT_CYC (edge 7 for the default).
- Stability requirement: a pulse on s shorter than FILT_CYC cycles never reaches f.
- z_rise is registered: z_rise<=r & ~z0. It is high exactly in the cycle z0 first reads 1.
- rise_cnt, with precedence clr > increment:
  - clr=1: rise_cnt<=0, even if a rise occurs in the same cycle.
  - Otherwise, rise_cnt increments when r & ~z0; at 2^CNT_W-1 it holds.
- z_sticky: clr=1 gives 0 (clr wins over a simultaneous set). Otherwise z_sticky<=z_sticky | (sticky_en & r).
  - z_sticky rises in the same cycle as z0.
  - z_sticky is held regardless of sticky_en until clr.
- Reset mid-filter: pending counts are discarded. After release, each channel needs a full FILT_CYC window again.

Decomposition:
- Package logic_reduce_pkg holds the MODE_OR..MODE_XNOR 3-bit constants and the identity function/constant per mode.
- One sub-module, input_debounce (parameter FILT_CYC): 2-flop synchroniser plus filter counter for one channel, giving f.
  - It is instantiated N times via generate.
  - Counter width is $clog2(FILT_CYC)+1.
- Reduction, z0, z_rise, counter and sticky logic live in the top level.

Test Plan (N=3, FILT_CYC=4, CNT_W=8):
- Reset, then mode=OR, mask=111, x=000, giving z0=0. Drive x=010 before edge 1 and hold it. Required: z0=1 and z_rise=1 at edge 7 only, z_rise=0 at edge 8, rise_cnt=1.
- Glitch rejection: x[1] high for 3 cycles, then low. Required: f, z0 and rise_cnt unchanged. The same pulse held 4 cycles passes and gives z0=1.
- Mode/mask sweep with f=101, mask=111. Required after 1 edge:
  - OR 1, AND 0, XOR 0, NOR 0, NAND 1, XNOR 1, mode=110 gives 1.
  - mask=000 with AND gives 1; mask=000 with NOR gives 1.
- Counter: 300 rise events give rise_cnt=255 (saturated). clr asserted in the same cycle as a rise gives rise_cnt=0 and z_sticky=0.
- Sticky: sticky_en=1, z0 high for 1 cycle then low. Required: z_sticky stays 1 until clr. With sticky_en=0, z0 high leaves z_sticky=0.
- Async reset: assert rstn low mid-filter (counter=2) and between edges. Required: all outputs 0 immediately. After release with x held, z0 changes only after a fresh 3+FILT_CYC edges.
